wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Shares the common Wishbone bus between the VM2 CPU and up to NREQ DMA masters (disk/net controllers).
//  Drives the CPU's bus-grant input: 1 = CPU owns the bus (default), 0 = a DMA master owns it.
//  Uses round-robin among DMA requesters, a hold-time limit per DMA tenure, and a grant-acceptance watchdog.
// PARAMETERS
//  NREQ      4    number of DMA requesters (1..8)
//  MAXHOLD   64   max clk_p cycles a DMA master may keep grant while others/CPU wait (>=2)
//  GNT_TMO   16   cycles a granted master has to raise dma_cyc before grant is revoked (>=2)
// PORTS
//  clk_p         in   1        system clock, all logic on rising edge
//  rst_n         in   1        asynchronous active-low reset
//  cpu_cyc       in   1        CPU Wishbone cycle strobe (local_cyc qualified to common bus)
//  cpu_gnt       out  1        grant to CPU (connects to cpu_gnt_i)
//  dma_req       in   NREQ     bus request per DMA master, level, held until done
//  dma_cyc       in   NREQ     Wishbone cycle strobe per DMA master
//  dma_gnt       out  NREQ     one-hot grant per DMA master
//  owner         out  3        index of granted DMA master (valid when busy)
//  busy          out  1        1 = some DMA master owns the bus
//  tmo_evt       out  1        1-cycle pulse: grant revoked by watchdog
// BEHAVIOUR
//  Reset (rst_n=0, async): state=CPU, cpu_gnt=1, dma_gnt=0, owner=0, busy=0, tmo_evt=0, rr pointer=0, counters=0.
//  All outputs registered; state changes on rising clk_p only.
//  States: CPU, DRAIN, GRANT, HOLD, GAP.
//   CPU:   cpu_gnt=1. If |dma_req -> DRAIN next cycle.
//   DRAIN: cpu_gnt=0 immediately on entry; wait until cpu_cyc=0 (CPU's in-flight cycle completes,
//          CPU then stalls on ack). When cpu_cyc=0 and |dma_req: select winner -> GRANT.
//          If dma_req drops to 0 while draining -> CPU.
//   Winner: first requester at index >= rr, searching upward modulo NREQ; rr <- winner+1 (mod NREQ)
//          at grant time.
//   GRANT: dma_gnt[winner]=1, busy=1, owner=winner; tmo counter counts. dma_cyc[winner]=1 -> HOLD.
//          Counter reaches GNT_TMO-1 without dma_cyc -> revoke, tmo_evt=1 for one cycle -> GAP.
//   HOLD:  hold counter counts every cycle. dma_req[winner]=0 and dma_cyc[winner]=0 -> GAP.
//          Counter >= MAXHOLD-1 and (other dma_req or cpu_cyc pending): deassert grant only when
//          dma_cyc[winner]=0 (never abort a cycle in progress) -> GAP.
//          Counter saturates at MAXHOLD-1; no wrap.
//   GAP:   exactly one cycle, all grants 0, busy=0. Then: |dma_req and no CPU demand -> GRANT (new
//          winner, no DRAIN needed since cpu_gnt already 0); cpu_cyc=1 -> CPU; otherwise -> CPU.
//          CPU priority: after any DMA tenure, if cpu_cyc=1 in GAP the CPU gets the bus before the next
//          DMA grant (prevents CPU starvation).
//  dma_gnt and cpu_gnt never both 1; at most one dma_gnt bit set (checked by assertion).
//  dma_req/dma_cyc from non-granted masters ignored except as arbitration input.
//  Requester withdrawing dma_req while in GRANT (before dma_cyc): treated as release -> GAP, no tmo_evt.
//  Simultaneous watchdog expiry and dma_cyc rise in same cycle: dma_cyc wins -> HOLD.
//  Reset mid-tenure: grant drops asynchronously, CPU re-granted; master must re-request.
//  owner is zero-extended for NREQ<8; holds last value when busy=0.
// TESTING
//  1 Reset, no requests -> cpu_gnt=1, dma_gnt=0 indefinitely; CPU cycles pass unhindered.
//  2 cpu_cyc=1 held 5 cycles, dma_req=4'b0100 -> cpu_gnt=0 next cycle, dma_gnt=4'b0100 1 cycle after
//    cpu_cyc falls; release -> 1-cycle GAP -> cpu_gnt=1.
//  3 dma_req=4'b1111 held, each master cycles 3 clocks then releases -> grants in order 0,1,2,3,0;
//    CPU idle so no CPU tenures between.
//  4 Master 1 granted, never raises dma_cyc -> dma_gnt[1] drops after 16 cycles, tmo_evt pulses once.
//  5 Master 0 holds dma_cyc continuously with dma_req[2] pending -> grant kept while dma_cyc=1; at
//    first dma_cyc=0 after 64 cycles grant moves (GAP) to master 2.
//  6 rst_n low during HOLD -> dma_gnt=0, cpu_gnt=1 same instant; after release, rr=0 arbitration.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Common Wishbone bus arbiter between the VM2 CPU (default owner) and NREQ DMA masters.
// Round-robin DMA selection, per-tenure hold limit and grant-acceptance watchdog.
//
// state | meaning
// CPU   | CPU owns the bus
// DRAIN | CPU grant removed, waiting for its in-flight cycle to end
// GRANT | DMA master granted, waiting for its dma_cyc
// HOLD  | granted DMA master running bus cycles
// GAP   | single idle cycle between tenures
module wb_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 64,
  parameter int GNT_TMO = 16
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            cpu_cyc,
  output logic            cpu_gnt,
  input  logic [NREQ-1:0] dma_req,
  input  logic [NREQ-1:0] dma_cyc,
  output logic [NREQ-1:0] dma_gnt,
  output logic [2:0]      owner,
  output logic            busy,
  output logic            tmo_evt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(GNT_TMO);
  localparam int HW = $clog2(MAXHOLD);

  typedef enum logic [2:0] {S_CPU, S_DRAIN, S_GRANT, S_HOLD, S_GAP} state_t;

  state_t        state;
  logic [2:0]    rr;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;

  logic [IW-1:0] k;
  logic          found;
  logic [2:0]    win;
  logic [2:0]    rr_next;
  logic          cyc_w;
  logic          req_w;
  logic          others;
  logic          any_req;

  // first requester at or above rr, wrapping modulo NREQ
  always_comb begin
    k     = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((int'(rr) + i) % NREQ);
      if (!found && dma_req[k]) begin
        found = 1'b1;
        win   = 3'(k);
      end
    end
  end

  assign rr_next = 3'((int'(win) + 1) % NREQ);

  // dma_gnt holds the current winner's one-hot mask during GRANT/HOLD
  assign cyc_w   = |(dma_cyc & dma_gnt);
  assign req_w   = |(dma_req & dma_gnt);
  assign others  = |(dma_req & ~dma_gnt);
  assign any_req = |dma_req;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CPU;
      cpu_gnt  <= 1'b1;
      dma_gnt  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      tmo_evt  <= 1'b0;
      rr       <= '0;
      tmo_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      tmo_evt <= 1'b0;
      case (state)
        S_CPU: begin
          if (any_req) begin
            state   <= S_DRAIN;
            cpu_gnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!any_req) begin
            state   <= S_CPU;
            cpu_gnt <= 1'b1;
          end else if (!cpu_cyc) begin
            state   <= S_GRANT;
            dma_gnt <= NREQ'(1) << win;
            owner   <= win;
            busy    <= 1'b1;
            rr      <= rr_next;
            tmo_cnt <= TW'(GNT_TMO - 1);
          end
        end
        S_GRANT: begin
          // a cycle starting on the expiry edge still wins over the watchdog
          if (cyc_w) begin
            state    <= S_HOLD;
            hold_cnt <= HW'(MAXHOLD - 1);
          end else if (!req_w) begin
            state   <= S_GAP;
            dma_gnt <= '0;
            busy    <= 1'b0;
          end else if (tmo_cnt == '0) begin
            state   <= S_GAP;
            dma_gnt <= '0;
            busy    <= 1'b0;
            tmo_evt <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if ((!req_w && !cyc_w) || (hold_cnt == '0 && (others || cpu_cyc) && !cyc_w)) begin
            state   <= S_GAP;
            dma_gnt <= '0;
            busy    <= 1'b0;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (!cpu_cyc && any_req) begin
            state   <= S_GRANT;
            dma_gnt <= NREQ'(1) << win;
            owner   <= win;
            busy    <= 1'b1;
            rr      <= rr_next;
            tmo_cnt <= TW'(GNT_TMO - 1);
          end else begin
            state   <= S_CPU;
            cpu_gnt <= 1'b1;
          end
        end
        default: begin
          state   <= S_CPU;
          cpu_gnt <= 1'b1;
          dma_gnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clk_p) disable iff (!rst_n)
    !(cpu_gnt && (|dma_gnt)) && $onehot0(dma_gnt));

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: per-scenario tasks, reactive DMA masters and a
// cycle-level reference model of the arbitration rules.
module tb_wb_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int MAXHOLD = 64;
  localparam int GNT_TMO = 16;
  localparam int P_CPU = 0, P_DRAIN = 1, P_GRANT = 2, P_HOLD = 3, P_GAP = 4;

  logic            clk_p   = 1'b0;
  logic            rst_n   = 1'b0;
  logic            cpu_cyc = 1'b0;
  logic [NREQ-1:0] dma_req = '0;
  logic [NREQ-1:0] dma_cyc = '0;
  logic            cpu_gnt;
  logic [NREQ-1:0] dma_gnt;
  logic [2:0]      owner;
  logic            busy;
  logic            tmo_evt;

  int n_vec = 0;
  int n_err = 0;

  int              m_ph, m_own, m_rr, m_age;
  logic            e_cpu, e_busy, e_tmo;
  logic [NREQ-1:0] e_gnt;
  logic [2:0]      e_own;

  int act[NREQ], rest_cnt[NREQ], len[NREQ], rest[NREQ];
  bit lazy[NREQ], en[NREQ];
  bit rnd = 1'b0;

  wb_bus_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD), .GNT_TMO(GNT_TMO)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .cpu_cyc(cpu_cyc), .cpu_gnt(cpu_gnt),
    .dma_req(dma_req), .dma_cyc(dma_cyc), .dma_gnt(dma_gnt),
    .owner(owner), .busy(busy), .tmo_evt(tmo_evt)
  );

  always #5 clk_p = ~clk_p;

  function automatic void model_reset();
    m_ph = P_CPU; m_own = 0; m_rr = 0; m_age = 0;
    e_cpu = 1'b1; e_gnt = '0; e_own = '0; e_busy = 1'b0; e_tmo = 1'b0;
  endfunction

  function automatic void model_gap();
    m_ph = P_GAP; e_gnt = '0; e_busy = 1'b0; e_cpu = 1'b0;
  endfunction

  function automatic void model_cpu();
    m_ph = P_CPU; e_cpu = 1'b1;
  endfunction

  function automatic void model_pick();
    int j;
    for (int i = 0; i < NREQ; i++) begin
      j = (m_rr + i) % NREQ;
      if (dma_req[j]) begin
        m_own = j; m_rr = (j + 1) % NREQ; m_age = 0; m_ph = P_GRANT;
        e_gnt = '0; e_gnt[j] = 1'b1; e_own = 3'(j); e_busy = 1'b1;
        return;
      end
    end
  endfunction

  // expected registered outputs after the coming edge, from the inputs now applied
  function automatic void model_step();
    bit pend;
    e_tmo = 1'b0;
    case (m_ph)
      P_CPU:   if (dma_req != 0) begin m_ph = P_DRAIN; e_cpu = 1'b0; end
      P_DRAIN: if (dma_req == 0) model_cpu(); else if (!cpu_cyc) model_pick();
      P_GRANT: begin
        if (dma_cyc[m_own]) begin m_ph = P_HOLD; m_age = 0; end
        else if (!dma_req[m_own]) model_gap();
        else if (m_age == GNT_TMO - 1) begin model_gap(); e_tmo = 1'b1; end
        else m_age++;
      end
      P_HOLD: begin
        pend = cpu_cyc;
        for (int i = 0; i < NREQ; i++) if (i != m_own && dma_req[i]) pend = 1'b1;
        if (!dma_req[m_own] && !dma_cyc[m_own]) model_gap();
        else if (m_age >= MAXHOLD - 1 && pend && !dma_cyc[m_own]) model_gap();
        else if (m_age < MAXHOLD - 1) m_age++;
      end
      default: if (cpu_cyc || dma_req == 0) model_cpu(); else model_pick();
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < NREQ; i++) begin
      if (dma_gnt[i] && !lazy[i]) begin
        if (act[i] < len[i]) begin
          dma_cyc[i] = 1'b1; act[i]++;
        end else begin
          dma_cyc[i] = 1'b0; dma_req[i] = 1'b0; act[i] = 0;
          if (rnd) begin len[i] = $urandom_range(1, 5); rest[i] = $urandom_range(0, 6); end
          rest_cnt[i] = rest[i];
        end
      end else if (!dma_gnt[i]) begin
        dma_cyc[i] = 1'b0;
        if (!dma_req[i]) begin
          if (rest_cnt[i] > 0) rest_cnt[i]--;
          else if (en[i]) dma_req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_p);
    rst_n = 1'b0; cpu_cyc = 1'b0; dma_req = '0; dma_cyc = '0; rnd = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      act[i] = 0; rest_cnt[i] = 0; len[i] = 3; rest[i] = 0; lazy[i] = 1'b0; en[i] = 1'b0;
    end
    model_reset();
    @(negedge clk_p);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #7;
    n_vec++;
    if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {1'b1, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values got %b required %b", {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, 10'b1_0000_000_0_0);
    end
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cpu_cyc = ($urandom_range(0, 1) == 1);
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL idle_cpu t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
    end
  endtask

  task automatic test_cpu_drain();
    do_reset();
    en[2] = 1'b1; len[2] = 3; rest[2] = 1000;
    dma_req = 4'b0100;
    for (int c = 1; c <= 14; c++) begin
      cpu_cyc = (c <= 5);
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL cpu_drain t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (c == 1 || c == 5 || c == 6 || c == 10 || c == 11) begin
        n_vec++;
        if ((c == 1 && cpu_gnt !== 1'b0) || (c == 5 && dma_gnt !== 4'b0000) ||
            (c == 6 && dma_gnt !== 4'b0100) || (c == 10 && {cpu_gnt, dma_gnt, busy} !== 6'b0) ||
            (c == 11 && cpu_gnt !== 1'b1)) begin
          n_err++;
          $display("FAIL drain_timing cycle %0d got cpu_gnt=%b dma_gnt=%b busy=%b", c, cpu_gnt, dma_gnt, busy);
        end
      end
      drive_masters();
    end
  endtask

  task automatic test_rr_order();
    int got[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] prev;
    int cpu_ten;
    prev = '0; cpu_ten = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1'b1; len[i] = 3; rest[i] = 0; end
    drive_masters();
    for (int c = 0; c < 200 && got.size() < 5; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL rr_cycle t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (dma_gnt != 0 && prev == 0) got.push_back(int'(owner));
      if (got.size() > 0 && got.size() < 5 && cpu_gnt) cpu_ten++;
      prev = dma_gnt;
      drive_masters();
    end
    n_vec++;
    if (got.size() != 5) begin
      n_err++;
      $display("FAIL rr_grant_count got %0d grants required 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (got[k] != exp_ord[k]) begin
          n_err++;
          $display("FAIL rr_order grant %0d got owner %0d required %0d", k, got[k], exp_ord[k]);
        end
      end
    end
    n_vec++;
    if (cpu_ten != 0) begin
      n_err++;
      $display("FAIL rr_no_cpu got %0d cpu cycles required 0", cpu_ten);
    end
  endtask

  task automatic test_timeout();
    int gcnt, tcnt, c_set;
    gcnt = 0; tcnt = 0; c_set = -1;
    do_reset();
    en[1] = 1'b1; lazy[1] = 1'b1;
    drive_masters();
    for (int c = 0; c < 40; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL tmo_cycle t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (dma_gnt[1]) gcnt++;
      if (tmo_evt) begin tcnt++; en[1] = 1'b0; dma_req[1] = 1'b0; end
      drive_masters();
    end
    n_vec++;
    if (gcnt != GNT_TMO || tcnt != 1) begin
      n_err++;
      $display("FAIL tmo_revoke got grant_cycles=%0d pulses=%0d required %0d and 1", gcnt, tcnt, GNT_TMO);
    end
    // withdrawal before dma_cyc is a plain release
    gcnt = 0; tcnt = 0;
    dma_req[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL withdraw_cycle t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (dma_gnt[1]) gcnt++;
      if (tmo_evt) tcnt++;
      if (gcnt == 3) dma_req[1] = 1'b0;
    end
    n_vec++;
    if (gcnt != 3 || tcnt != 0) begin
      n_err++;
      $display("FAIL withdraw got grant_cycles=%0d pulses=%0d required 3 and 0", gcnt, tcnt);
    end
    gcnt = 0;
    dma_req[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL race_cycle t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (c == c_set + 1 && c_set >= 0) begin
        n_vec++;
        if ({dma_gnt, busy, tmo_evt} !== {4'b0010, 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL tmo_vs_cyc got gnt=%b busy=%b tmo=%b required 0010 1 0", dma_gnt, busy, tmo_evt);
        end
        dma_req[1] = 1'b0; dma_cyc[1] = 1'b0;
      end
      if (dma_gnt[1]) gcnt++;
      if (gcnt == GNT_TMO && c_set < 0) begin dma_cyc[1] = 1'b1; c_set = c; end
    end
    n_vec++;
    if (c_set < 0) begin
      n_err++;
      $display("FAIL tmo_vs_cyc_reach got grant_cycles=%0d required %0d", gcnt, GNT_TMO);
    end
  endtask

  task automatic test_maxhold();
    int g0, c_drop;
    bit first_done;
    g0 = 0; c_drop = -1; first_done = 1'b0;
    do_reset();
    dma_req = 4'b0001;
    for (int c = 0; c < 120; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL hold_cycle t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (c == c_drop + 1 && c_drop >= 0) begin
        n_vec++;
        if ({dma_gnt, owner} !== {4'b0100, 3'd2}) begin
          n_err++;
          $display("FAIL hold_move got gnt=%b owner=%0d required 0100 2", dma_gnt, owner);
        end
        dma_req = 4'b0000; dma_cyc = 4'b0000;
      end
      if (!first_done && g0 > 0 && !dma_gnt[0]) begin
        first_done = 1'b1; c_drop = c;
        n_vec++;
        if (g0 != 70 || busy !== 1'b0 || dma_gnt !== 4'b0000) begin
          n_err++;
          $display("FAIL hold_limit got grant_cycles=%0d gap gnt=%b busy=%b required 70 0000 0", g0, dma_gnt, busy);
        end
      end
      if (dma_gnt[0] && !first_done) begin
        g0++;
        if (g0 == 2) dma_req[2] = 1'b1;
        dma_cyc[0] = (g0 < 70) && (g0 != 30);
      end else begin
        dma_cyc[0] = 1'b0;
      end
    end
    n_vec++;
    if (c_drop < 0) begin
      n_err++;
      $display("FAIL hold_timeout got grant_cycles=%0d required release", g0);
    end
  endtask

  task automatic test_reset_mid();
    int seen, first_own;
    seen = 0; first_own = -1;
    do_reset();
    dma_req = 4'b0100;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL pre_reset t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (dma_gnt[2]) begin seen++; dma_cyc[2] = 1'b1; end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {1'b1, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset got %b required %b", {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, 10'b1_0000_000_0_0);
    end
    model_reset();
    dma_req = '0; dma_cyc = '0;
    @(negedge clk_p);
    rst_n = 1'b1;
    dma_req = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL post_reset t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      if (busy && first_own < 0) begin first_own = int'(owner); dma_req = '0; end
    end
    n_vec++;
    if (first_own != 1) begin
      n_err++;
      $display("FAIL rr_after_reset got owner %0d required 1", first_own);
    end
  endtask

  task automatic test_random();
    do_reset();
    rnd = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1'b1; len[i] = $urandom_range(1, 5); rest[i] = $urandom_range(0, 6);
      lazy[i] = ($urandom_range(0, 9) == 0);
    end
    for (int c = 0; c < 500; c++) begin
      cpu_cyc = ($urandom_range(0, 3) == 0);
      tick();
      n_vec++;
      if ({cpu_gnt, dma_gnt, owner, busy, tmo_evt} !== {e_cpu, e_gnt, e_own, e_busy, e_tmo}) begin
        n_err++;
        $display("FAIL random t=%0t got %b required %b", $time,
                 {cpu_gnt, dma_gnt, owner, busy, tmo_evt}, {e_cpu, e_gnt, e_own, e_busy, e_tmo});
      end
      drive_masters();
    end
  endtask

  initial begin
    test_reset();
    test_cpu_drain();
    test_rr_order();
    test_timeout();
    test_maxhold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
